ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
- Hardwired control unit for the single-bus CPU datapath.
- Replaces hand-sequenced bench stimulus: generates the one-hot bus-select and register-enable vectors, ALU op, and memory strobes for fetch plus execute of ld, st, addi, andi, ori and halt.
- Generalises fixed-timing T0–T7 stepping: memory steps stall on a ready handshake; widths are parametrised; instructions are counted.

Parameters:
- NUM_SRC, 32, width of one-hot bus_sel vector.
- NUM_EN, 32, width of register-enable vector.
- OP_W, 5, width of opcode field and ALU control code.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- run  in  1  level; permits fetch of the next instruction.
- ir_op  in  OP_W  opcode field of IR; valid from T3 onward.
- mem_ready  in  1  RAM handshake; access completes in a cycle where it is high.
- bus_sel  out  NUM_SRC  one-hot bus source (all zero = bus idle).
- enable  out  NUM_EN  register load enables.
- alu_op  out  OP_W  ALU control code.
- md_read, read_ram, write_ram  out  1 each  MDR mux select / RAM read / RAM write.
- gra, grb, grc, r_in, r_out, ba_out  out  1 each  select-and-encode controls.
- busy  out  1  high in T0..T7.
- halted  out  1  high in HALT.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT; binary-encoded register.
- Outputs are Moore, decoded combinationally from state and op_q. All outputs are zero in IDLE and HALT.
- clr low, asynchronous: state=IDLE, op_q=0, instr_count=0.
- IDLE: go to T0 when run=1, otherwise stay.
- T0: bus_sel[PC]; enable[MAR]; enable[Z]; alu_op=INCPC (14); next T1.
- T1: bus_sel[ZLO]; enable[PC]; enable[MDR]; md_read; read_ram.
  - Stay in T1 while mem_ready=0.
  - enable[PC] is asserted only in the exit cycle, so PC increments exactly once.
  - Next T2.
- T2: bus_sel[MDR]; enable[IR]; next T3.
- T3: op_q <= ir_op at cycle end.
  - ALUI class (ADDI/ANDI/ORI): grb, r_out, enable[Y].
  - LD/ST: grb, ba_out, enable[Y].
  - HALT opcode: next HALT.
  - Unknown opcode: retire as NOP and exit (see retire rule).
  - All other opcodes: next T4.
- T4: bus_sel[C]; enable[Z].
  - alu_op: ADDI/LD/ST → ADD (1); ANDI → AND (3); ORI → OR (4).
  - Next T5.
- T5:
  - ALUI: bus_sel[ZLO], gra, r_in; retire.
  - LD/ST: bus_sel[ZLO], enable[MAR]; next T6.
- T6:
  - LD: md_read, read_ram, enable[MDR]; hold until mem_ready=1; next T7.
  - ST: gra, r_out, enable[MDR], md_read=0; next T7.
- T7:
  - LD: bus_sel[MDR], gra, r_in; retire.
  - ST: write_ram; hold until mem_ready=1; retire on acceptance.
- Retire: instr_count++ (wraps 2^CNT_W−1 → 0). Next T0 if run=1, else IDLE.
- run is sampled only at IDLE and at retire. Deasserting run mid-instruction completes that instruction.
- HALT: sticky until clr. Counter frozen; the halt itself is not counted.
- Invariants, all states: bus_sel has at most one bit set; read_ram and write_ram are never both high.
- mem_ready is ignored outside T1/T6(LD)/T7(ST).
- Reset mid-stall: aborts immediately; no write_ram glitch after clr rises.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - Retire always goes to IDLE.
  - IDLE→T0 requires run=1 and a rising edge of step, detected internally with a registered copy of step.
  - step held high does not re-trigger.
- Undefined: no step port; continuous execution as above.

Decomposition:
- Package ctrl_pkg:
  - State enum.
  - Opcode constants: LD=0, ST=2, ADDI=6, ANDI=7, ORI=8, HALT=27.
  - ALU codes: ADD=1, AND=3, OR=4, INCPC=14.
  - Bus-source indices: ZLO=19, PC=20, MDR=21, INPORT=22, C=23.
  - Enable indices: Z=18, Y=19, PC=20, MDR=21, IR=24, MAR=25.
- One sub-module: ctrl_decode (combinational state+op_q → output vector).
- FSM and counter stay in ctrl_sequencer.

Test Plan:
- ORI, mem_ready tied 1, run=1 → T0..T5 in 6 cycles.
  - T4 shows alu_op=4 with bus_sel[23] and enable[18].
  - T5 shows bus_sel[19], gra, r_in.
  - instr_count 0→1.
- LD with mem_ready low 3 cycles in T1 and 2 in T6 → T1 lasts 4 cycles and T6 lasts 3. enable[20] is high in exactly 1 cycle. Total 13 cycles.
- ST → write_ram high only in T7, until mem_ready=1. read_ram is never high in T6. instr_count increments once.
- run dropped during T4 of ADDI → instruction completes through T5, then IDLE. busy=0. Count=1.
- Opcode 27 after two ANDIs → halted=1 and all outputs 0. Count stays 2. run toggling has no effect until clr pulses low.
- clr asserted mid-T6 stall → outputs 0 asynchronously, state IDLE, count 0. With SINGLE_STEP_EN, one step pulse runs exactly one instruction.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the single-bus CPU control sequencer.
// State encoding, opcodes, ALU codes, bus-source and register-enable indices.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_T7,
      S_HALT
   } state_t;

   typedef struct packed {
      logic md_read;
      logic read_ram;
      logic write_ram;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic ba_out;
   } strobe_t;

   localparam int OP_LD   = 0;
   localparam int OP_ST   = 2;
   localparam int OP_ADDI = 6;
   localparam int OP_ANDI = 7;
   localparam int OP_ORI  = 8;
   localparam int OP_HALT = 27;

   localparam int ALU_ADD   = 1;
   localparam int ALU_AND   = 3;
   localparam int ALU_OR    = 4;
   localparam int ALU_INCPC = 14;

   localparam int BUS_ZLO    = 19;
   localparam int BUS_PC     = 20;
   localparam int BUS_MDR    = 21;
   localparam int BUS_INPORT = 22;
   localparam int BUS_C      = 23;

   localparam int EN_Z   = 18;
   localparam int EN_Y   = 19;
   localparam int EN_PC  = 20;
   localparam int EN_MDR = 21;
   localparam int EN_IR  = 24;
   localparam int EN_MAR = 25;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of sequencer state and opcode into datapath controls.
// Only the T1 PC enable looks at mem_ready, so PC steps once per fetch.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int NUM_SRC = 32,
   parameter int NUM_EN  = 32,
   parameter int OP_W    = 5
) (
   input  state_t              i_state,
   input  logic [OP_W-1:0]     i_op,
   input  logic                i_mem_ready,
   output logic [NUM_SRC-1:0]  o_bus_sel,
   output logic [NUM_EN-1:0]   o_enable,
   output logic [OP_W-1:0]     o_alu_op,
   output strobe_t             o_strb
);

   logic w_ld;
   logic w_st;
   logic w_addi;
   logic w_andi;
   logic w_ori;
   logic w_alui;
   logic w_ldst;

   assign w_ld   = (i_op == OP_W'(OP_LD));
   assign w_st   = (i_op == OP_W'(OP_ST));
   assign w_addi = (i_op == OP_W'(OP_ADDI));
   assign w_andi = (i_op == OP_W'(OP_ANDI));
   assign w_ori  = (i_op == OP_W'(OP_ORI));
   assign w_alui = w_addi | w_andi | w_ori;
   assign w_ldst = w_ld | w_st;

   // Moore-style control word per state; everything idle by default
   always_comb begin
      o_bus_sel = '0;
      o_enable  = '0;
      o_alu_op  = '0;
      o_strb    = '0;
      unique case (i_state)
         S_T0: begin
            o_bus_sel[BUS_PC] = 1'b1;
            o_enable[EN_MAR]  = 1'b1;
            o_enable[EN_Z]    = 1'b1;
            o_alu_op          = OP_W'(ALU_INCPC);
         end
         S_T1: begin
            o_bus_sel[BUS_ZLO] = 1'b1;
            o_enable[EN_PC]    = i_mem_ready;
            o_enable[EN_MDR]   = 1'b1;
            o_strb.md_read     = 1'b1;
            o_strb.read_ram    = 1'b1;
         end
         S_T2: begin
            o_bus_sel[BUS_MDR] = 1'b1;
            o_enable[EN_IR]    = 1'b1;
         end
         S_T3: begin
            if (w_alui) begin
               o_strb.grb      = 1'b1;
               o_strb.r_out    = 1'b1;
               o_enable[EN_Y]  = 1'b1;
            end else if (w_ldst) begin
               o_strb.grb      = 1'b1;
               o_strb.ba_out   = 1'b1;
               o_enable[EN_Y]  = 1'b1;
            end
         end
         S_T4: begin
            o_bus_sel[BUS_C] = 1'b1;
            o_enable[EN_Z]   = 1'b1;
            if (w_addi | w_ldst)
               o_alu_op = OP_W'(ALU_ADD);
            else if (w_andi)
               o_alu_op = OP_W'(ALU_AND);
            else if (w_ori)
               o_alu_op = OP_W'(ALU_OR);
         end
         S_T5: begin
            o_bus_sel[BUS_ZLO] = 1'b1;
            if (w_alui) begin
               o_strb.gra  = 1'b1;
               o_strb.r_in = 1'b1;
            end else if (w_ldst) begin
               o_enable[EN_MAR] = 1'b1;
            end
         end
         S_T6: begin
            if (w_ld) begin
               o_strb.md_read   = 1'b1;
               o_strb.read_ram  = 1'b1;
               o_enable[EN_MDR] = 1'b1;
            end else if (w_st) begin
               o_strb.gra       = 1'b1;
               o_strb.r_out     = 1'b1;
               o_enable[EN_MDR] = 1'b1;
            end
         end
         S_T7: begin
            if (w_ld) begin
               o_bus_sel[BUS_MDR] = 1'b1;
               o_strb.gra         = 1'b1;
               o_strb.r_in        = 1'b1;
            end else if (w_st) begin
               o_strb.write_ram   = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus CPU datapath.
// Optional SINGLE_STEP_EN adds a step input: one instruction per step edge.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int NUM_SRC = 32,
   parameter int NUM_EN  = 32,
   parameter int OP_W    = 5,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               run,
`ifdef SINGLE_STEP_EN
   input  logic               step,
`endif
   input  logic [OP_W-1:0]    ir_op,
   input  logic               mem_ready,
   output logic [NUM_SRC-1:0] bus_sel,
   output logic [NUM_EN-1:0]  enable,
   output logic [OP_W-1:0]    alu_op,
   output logic               md_read,
   output logic               read_ram,
   output logic               write_ram,
   output logic               gra,
   output logic               grb,
   output logic               grc,
   output logic               r_in,
   output logic               r_out,
   output logic               ba_out,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   instr_count
);

   state_t           r_state;
   state_t           w_next;
   logic [OP_W-1:0]  r_op_q;
   logic [CNT_W-1:0] r_count;
   logic [OP_W-1:0]  w_op;
   logic             w_retire;
   logic             w_start;
   logic             w_cont;
   logic             w_ld;
   logic             w_st;
   logic             w_alui;
   logic             w_halt_op;
   strobe_t          w_strb;

`ifdef SINGLE_STEP_EN
   logic r_step_q;

   // Registered copy of step for rising-edge detection
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         r_step_q <= 1'b0;
      else
         r_step_q <= step;
   end

   assign w_start = run & step & ~r_step_q;
   assign w_cont  = 1'b0;
`else
   assign w_start = run;
   assign w_cont  = run;
`endif

   // IR is only valid from T3; op_q carries the opcode afterwards
   assign w_op      = (r_state == S_T3) ? ir_op : r_op_q;
   assign w_ld      = (w_op == OP_W'(OP_LD));
   assign w_st      = (w_op == OP_W'(OP_ST));
   assign w_alui    = (w_op == OP_W'(OP_ADDI)) |
                      (w_op == OP_W'(OP_ANDI)) |
                      (w_op == OP_W'(OP_ORI));
   assign w_halt_op = (w_op == OP_W'(OP_HALT));

   // State, latched opcode and retired-instruction counter
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= S_IDLE;
         r_op_q  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_T3)
            r_op_q <= ir_op;
         if (w_retire)
            r_count <= r_count + 1'b1;
      end
   end

   // Next-state logic; retire decides between next fetch and idle
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      unique case (r_state)
         S_IDLE: if (w_start) w_next = S_T0;
         S_T0:   w_next = S_T1;
         S_T1:   if (mem_ready) w_next = S_T2;
         S_T2:   w_next = S_T3;
         S_T3: begin
            if (w_halt_op)
               w_next = S_HALT;
            else if (w_alui | w_ld | w_st)
               w_next = S_T4;
            else
               w_retire = 1'b1;
         end
         S_T4:   w_next = S_T5;
         S_T5: begin
            if (w_alui)
               w_retire = 1'b1;
            else
               w_next = S_T6;
         end
         S_T6: begin
            if (!w_ld || mem_ready)
               w_next = S_T7;
         end
         S_T7: begin
            if (w_ld || mem_ready)
               w_retire = 1'b1;
         end
         S_HALT: w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
      if (w_retire)
         w_next = w_cont ? S_T0 : S_IDLE;
   end

   ctrl_decode #(
      .NUM_SRC (NUM_SRC),
      .NUM_EN  (NUM_EN),
      .OP_W    (OP_W)
   ) u_decode (
      .i_state     (r_state),
      .i_op        (w_op),
      .i_mem_ready (mem_ready),
      .o_bus_sel   (bus_sel),
      .o_enable    (enable),
      .o_alu_op    (alu_op),
      .o_strb      (w_strb)
   );

   assign md_read     = w_strb.md_read;
   assign read_ram    = w_strb.read_ram;
   assign write_ram   = w_strb.write_ram;
   assign gra         = w_strb.gra;
   assign grb         = w_strb.grb;
   assign grc         = w_strb.grc;
   assign r_in        = w_strb.r_in;
   assign r_out       = w_strb.r_out;
   assign ba_out      = w_strb.ba_out;
   assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
   assign halted      = (r_state == S_HALT);
   assign instr_count = r_count;

endmodule
